// File: rtl/button_event_arbiter.sv
// Button conditioning (sync, debounce, rising-edge) feeding a round-robin valid/ready event arbiter.
// Optional macro BTN_ARB_OVERRUN_CNT_EN adds a saturating dropped-press counter output overrun_cnt.
module button_event_arbiter #(
    parameter int unsigned NUM_BTN         = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned ID_W            = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_BTN-1:0] btn,
    output logic               evt_valid,
    output logic [ID_W-1:0]    evt_id,
    input  logic               evt_ready,
    output logic [NUM_BTN-1:0] btn_level,
    output logic               overrun
`ifdef BTN_ARB_OVERRUN_CNT_EN
    ,
    output logic [7:0]         overrun_cnt
`endif
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);

    typedef enum logic {IDLE, OFFER} state_t;

    state_t             state;
    logic [NUM_BTN-1:0] s1, s2, level_d, rise, pending, accept, drop;
    logic [CNT_W-1:0]   cnt [NUM_BTN];
    logic [ID_W-1:0]    rr_ptr, pick_id, next_ptr;
    logic               pick_ok;

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1        <= '0;
            s2        <= '0;
            level_d   <= '0;
            btn_level <= '0;
            for (int unsigned i = 0; i < NUM_BTN; i++) cnt[i] <= '0;
        end else begin
            s1      <= btn;
            s2      <= s1;
            level_d <= btn_level;
            for (int unsigned i = 0; i < NUM_BTN; i++) begin
                if (s2[i] == btn_level[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    btn_level[i] <= ~btn_level[i];
                    cnt[i]       <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign rise = btn_level & ~level_d;
    assign drop = rise & pending & ~accept;

    always_comb begin
        accept = '0;
        if (state == OFFER && evt_ready) accept[evt_id] = 1'b1;
    end

    // Two passes give the cyclic search: indices at/after rr_ptr first, then wrap from 0.
    always_comb begin
        pick_ok = 1'b0;
        pick_id = '0;
        for (int unsigned i = 0; i < NUM_BTN; i++) begin
            if (!pick_ok && pending[i] && i >= 32'(rr_ptr)) begin
                pick_ok = 1'b1;
                pick_id = ID_W'(i);
            end
        end
        for (int unsigned i = 0; i < NUM_BTN; i++) begin
            if (!pick_ok && pending[i]) begin
                pick_ok = 1'b1;
                pick_id = ID_W'(i);
            end
        end
    end

    assign next_ptr = (evt_id == ID_W'(NUM_BTN - 1)) ? '0 : evt_id + ID_W'(1);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            evt_valid <= 1'b0;
            evt_id    <= '0;
            rr_ptr    <= '0;
            pending   <= '0;
            overrun   <= 1'b0;
        end else begin
            // A new press in the accept cycle survives: set wins over clear.
            pending <= (pending & ~accept) | rise;
            if (|drop) overrun <= 1'b1;
            case (state)
                IDLE: begin
                    if (pick_ok) begin
                        evt_id    <= pick_id;
                        evt_valid <= 1'b1;
                        state     <= OFFER;
                    end
                end
                OFFER: begin
                    if (evt_ready) begin
                        evt_valid <= 1'b0;
                        rr_ptr    <= next_ptr;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef BTN_ARB_OVERRUN_CNT_EN
    logic [4:0] drop_n;
    logic [8:0] cnt_sum;

    always_comb begin
        drop_n = '0;
        for (int unsigned i = 0; i < NUM_BTN; i++) drop_n = drop_n + {4'b0, drop[i]};
    end

    assign cnt_sum = {1'b0, overrun_cnt} + {4'b0, drop_n};

    always_ff @(posedge clk) begin
        if (!rst)            overrun_cnt <= '0;
        else if (cnt_sum[8]) overrun_cnt <= 8'hFF;
        else                 overrun_cnt <= cnt_sum[7:0];
    end
`endif

endmodule

// File: tb/tb_button_event_arbiter.sv
// Bench for button_event_arbiter: directed scenarios plus random stimulus against a behavioural model.
module tb_button_event_arbiter;

    localparam int N  = 4;
    localparam int D  = 4;
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [N-1:0]  btn = '0;
    logic          evt_ready = 1'b1;
    logic          evt_valid;
    logic [IW-1:0] evt_id;
    logic [N-1:0]  btn_level;
    logic          overrun;
`ifdef BTN_ARB_OVERRUN_CNT_EN
    logic [7:0]    overrun_cnt;
`endif

    always #5 clk = ~clk;

    button_event_arbiter #(.NUM_BTN(N), .DEBOUNCE_CYCLES(D), .ID_W(IW)) dut (
        .clk(clk), .rst(rst), .btn(btn),
        .evt_valid(evt_valid), .evt_id(evt_id), .evt_ready(evt_ready),
        .btn_level(btn_level), .overrun(overrun)
`ifdef BTN_ARB_OVERRUN_CNT_EN
        , .overrun_cnt(overrun_cnt)
`endif
    );

    int passed = 0;
    int total  = 0;
    int failed = 0;
    int n_acc  = 0;
    int ev0;

    // Reference model: spec-level state, updated once per rising edge.
    logic [N-1:0] m_s1 = '0, m_s2 = '0, m_lvl = '0, m_prev = '0, m_pend = '0;
    int           m_run [N];
    bit           m_off = 0;
    int           m_id = 0, m_rr = 0, m_cnt = 0;
    bit           m_ovr = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        logic [N-1:0] rise, acc;
        bit           found;
        int           j;
        if (!rst) begin
            m_s1 = '0; m_s2 = '0; m_lvl = '0; m_prev = '0; m_pend = '0;
            for (int i = 0; i < N; i++) m_run[i] = 0;
            m_off = 0; m_id = 0; m_rr = 0; m_ovr = 0; m_cnt = 0;
        end else begin
            rise = m_lvl & ~m_prev;
            acc  = '0;
            if (m_off && evt_ready) acc[m_id] = 1'b1;
            if (m_off) begin
                if (evt_ready) begin
                    m_off = 0;
                    m_rr  = (m_id + 1) % N;
                end
            end else begin
                found = 0;
                for (int k = 0; k < N; k++) begin
                    j = (m_rr + k) % N;
                    if (!found && m_pend[j]) begin
                        found = 1; m_id = j; m_off = 1;
                    end
                end
            end
            for (int i = 0; i < N; i++) begin
                if (rise[i] && m_pend[i] && !acc[i]) begin
                    m_ovr = 1;
                    if (m_cnt < 255) m_cnt++;
                end
            end
            m_pend = (m_pend & ~acc) | rise;
            m_prev = m_lvl;
            for (int i = 0; i < N; i++) begin
                if (m_s2[i] != m_lvl[i]) begin
                    m_run[i]++;
                    if (m_run[i] == D) begin
                        m_lvl[i] = ~m_lvl[i];
                        m_run[i] = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            m_s2 = m_s1;
            m_s1 = btn;
        end
    endtask

    task automatic tick();
        if (rst && evt_valid && evt_ready) n_acc++;
        @(posedge clk);
        model_edge();
        #1;
        chk("model_valid",   32'(evt_valid), 32'(m_off));
        chk("model_id",      32'(evt_id),    32'(m_id));
        chk("model_level",   32'(btn_level), 32'(m_lvl));
        chk("model_overrun", 32'(overrun),   32'(m_ovr));
`ifdef BTN_ARB_OVERRUN_CNT_EN
        chk("model_ovr_cnt", 32'(overrun_cnt), 32'(m_cnt));
`endif
    endtask

    task automatic hold(input int n);
        repeat (n) tick();
    endtask

    task automatic wait_valid(input int max_ticks);
        for (int k = 0; k < max_ticks && !evt_valid; k++) tick();
    endtask

    task automatic pair_test(input int first, input int second, input string tag);
        btn[0] = 1'b1; btn[3] = 1'b1;
        wait_valid(20);
        chk({tag, "_first_valid"}, 32'(evt_valid), 1);
        chk({tag, "_first_id"}, 32'(evt_id), first);
        tick();
        chk({tag, "_gap"}, 32'(evt_valid), 0);
        tick();
        chk({tag, "_second_valid"}, 32'(evt_valid), 1);
        chk({tag, "_second_id"}, 32'(evt_id), second);
        btn[0] = 1'b0; btn[3] = 1'b0;
        hold(15);
    endtask

    initial begin
        for (int i = 0; i < N; i++) m_run[i] = 0;

        hold(2);
        chk("rst_valid", 32'(evt_valid), 0);
        chk("rst_id", 32'(evt_id), 0);
        chk("rst_level", 32'(btn_level), 0);
        chk("rst_overrun", 32'(overrun), 0);
        rst = 1'b1;
        hold(3);

        // Clean press latency
        btn[2] = 1'b1;
        ev0 = n_acc;
        hold(7);
        chk("t1_early", 32'(evt_valid), 0);
        tick();
        chk("t1_valid", 32'(evt_valid), 1);
        chk("t1_id", 32'(evt_id), 2);
        hold(20);
        chk("t1_single_event", 32'(n_acc - ev0), 1);
        chk("t1_level", 32'(btn_level[2]), 1);
        btn[2] = 1'b0;
        hold(15);

        // Bounce rejection
        ev0 = n_acc;
        for (int r = 0; r < 5; r++) begin
            btn[1] = 1'b1; hold(3);
            btn[1] = 1'b0; hold(1);
        end
        hold(15);
        chk("t2_no_event", 32'(n_acc - ev0), 0);
        chk("t2_level", 32'(btn_level[1]), 0);
        chk("t2_overrun", 32'(overrun), 0);

        // Simultaneous presses and round-robin order
        rst = 1'b0; hold(2); rst = 1'b1;
        pair_test(0, 3, "t3a");
        pair_test(0, 3, "t3b");
        btn[0] = 1'b1;
        wait_valid(20);
        chk("t3_single_id", 32'(evt_id), 0);
        btn[0] = 1'b0;
        hold(15);
        pair_test(3, 0, "t3c");

        // Backpressure
        evt_ready = 1'b0;
        btn[1] = 1'b1;
        wait_valid(20);
        chk("t4_valid", 32'(evt_valid), 1);
        chk("t4_id", 32'(evt_id), 1);
        btn[2] = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
            chk("t4_hold_valid", 32'(evt_valid), 1);
            chk("t4_hold_id", 32'(evt_id), 1);
        end
        evt_ready = 1'b1;
        tick();
        chk("t4_idle_gap", 32'(evt_valid), 0);
        tick();
        chk("t4_next_valid", 32'(evt_valid), 1);
        chk("t4_next_id", 32'(evt_id), 2);
        btn[1] = 1'b0; btn[2] = 1'b0;
        hold(15);

        // Overrun
        chk("t5_pre_overrun", 32'(overrun), 0);
        evt_ready = 1'b0;
        btn[0] = 1'b1; hold(10);
        btn[0] = 1'b0; hold(10);
        btn[0] = 1'b1; hold(10);
        chk("t5_overrun", 32'(overrun), 1);
        chk("t5_valid", 32'(evt_valid), 1);
        chk("t5_id", 32'(evt_id), 0);
`ifdef BTN_ARB_OVERRUN_CNT_EN
        chk("t5_ovr_cnt", 32'(overrun_cnt), 1);
`endif
        ev0 = n_acc;
        evt_ready = 1'b1;
        btn[0] = 1'b0;
        hold(20);
        chk("t5_one_event", 32'(n_acc - ev0), 1);
        chk("t5_sticky", 32'(overrun), 1);

        // Reset mid-offer
        evt_ready = 1'b0;
        btn[3] = 1'b1;
        wait_valid(20);
        chk("t6_offer_id", 32'(evt_id), 3);
        btn[3] = 1'b0;
        rst = 1'b0;
        tick();
        chk("t6_valid", 32'(evt_valid), 0);
        chk("t6_id", 32'(evt_id), 0);
        chk("t6_overrun", 32'(overrun), 0);
        rst = 1'b1;
        evt_ready = 1'b1;
        ev0 = n_acc;
        hold(20);
        chk("t6_no_event", 32'(n_acc - ev0), 0);

        // Button held through reset release
        btn[1] = 1'b1;
        rst = 1'b0; hold(3); rst = 1'b1;
        wait_valid(20);
        chk("t7_valid", 32'(evt_valid), 1);
        chk("t7_id", 32'(evt_id), 1);
        btn[1] = 1'b0;
        hold(15);

        // Random traffic against the model
        for (int c = 0; c < 2000; c++) begin
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 15) == 0) btn[i] = ~btn[i];
            evt_ready = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 999) != 0);
            tick();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
